mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the MCU's single-ported memory between the IF stage (instruction fetch) and the MEM stage (lw/sw issued by the decoded memRead/memWrite controls).
- Round-robin arbitration with a registered memory-side request/ack handshake.
- Generates the if_stall / mem_stall signals the pipeline uses to freeze stages while their access is pending.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT_CYC, 15, wait-state limit; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request; held high with if_addr stable until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction; valid in the if_ack cycle, held until the next fetch ack
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid in the d_ack cycle, unchanged by stores
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack=1
- mem_ack  in  1  memory completion, sampled at the clock edge
- if_stall  out  1  if_req & ~if_ack
- mem_stall  out  1  d_req & ~d_ack
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset: asynchronous (rst_n low) clears all registered outputs to 0, state to IDLE and last_grant to I. mem_req drops immediately, even mid-transaction; the in-flight access is abandoned with no ack.
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE transitions:
  - Only d_req → GNT_D.
  - Only if_req → GNT_I.
  - Both requesting → the side not equal to last_grant wins. After reset, last_grant=I, so data wins the first tie.
  - Neither → stay in IDLE.
- On entering GNT_x:
  - Register mem_req=1 and the selected mem_addr / mem_we / mem_wdata; update last_grant.
  - Fetches force mem_we=0.
- While in GNT_x:
  - mem_* outputs are held constant until mem_ack is sampled high.
  - On mem_ack: clear mem_req and mem_we, go to RESP.
  - For a fetch or a load, capture mem_rdata into x_rdata.
  - Assert x_ack=1 during the RESP cycle.
- RESP:
  - Requests are ignored, because the requester's req is still high from the finished transaction.
  - Next state is IDLE.
- Throughput:
  - Minimum latency is 3 cycles: req at cycle 0, mem_req at cycle 1, ack at cycle 2 (zero-wait memory acks in cycle 1).
  - Each transaction occupies GNT + RESP + IDLE, so the sustained rate is 1 access per 3 cycles at zero wait.
- A request arriving while the other side is granted waits; its stall output stays high throughout.
- mem_ack outside GNT_x is ignored.
- Stall outputs are combinational from the req inputs and the registered ack outputs; there is no combinational path from mem_* inputs to any output.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on GNT entry and increments each GNT cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYC: drop mem_req, go to RESP and ack the requester.
  - Returned data: if_rdata=32'h0000_0013 (NOP) for fetches; d_rdata=0 for loads.
  - Set bus_err=1, sticky until reset.
- Not defined: the arbiter waits indefinitely for mem_ack; bus_err is tied to 0.

Decomposition:
- Shared package mcu_pkg holds:
  - FSM state encoding (2-bit: IDLE=0, GNT_I=1, GNT_D=2, RESP=3)
  - grant-select encoding (GRANT_I=0, GRANT_D=1)
  - constant NOP_INSTR=32'h0000_0013
- One natural sub-module: arb_wait_timer, the wait counter with a terminal flag. It is instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Fetch only, if_addr=0x100, memory acks in the same cycle as mem_req with rdata=0x00500093 → mem_req high in cycle 1; if_ack and if_rdata=0x00500093 in cycle 2; if_stall high in cycles 0-1.
- if_req and d_req (load, addr 0x2000) together right after reset → data granted first; fetch granted in the IDLE cycle after its RESP; last_grant then alternates.
- Store d_addr=0x10, d_wdata=0xDEADBEEF, with 3 wait states → mem_we=1 and data stable for 4 cycles; d_ack pulses once; d_rdata unchanged.
- rst_n pulled low mid-GNT_D with 2 wait states pending → mem_req=0 asynchronously; no d_ack; clean IDLE after release; a new fetch completes normally.
- (MEM_ARB_TIMEOUT_EN) fetch with mem_ack never asserted → after 15 GNT cycles, if_ack with if_rdata=0x00000013; bus_err=1 and stays high.
- Back-to-back continuous if_req with zero-wait memory → if_ack every 3rd cycle; no duplicate grant in the RESP cycle.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types and constants for the MCU memory-bus arbiter.
package mcu_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2,
    StResp = 2'd3
  } arb_state_e;

  typedef enum logic {
    GrantI = 1'b0,
    GrantD = 1'b1
  } grant_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/arb_wait_timer.sv
// Counts memory wait states of a granted access; flags the cycle in which the limit is reached.
module arb_wait_timer #(
  parameter int unsigned Limit = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires on the wait cycle whose increment would bring the count to Limit.
  assign expire_o = inc_i && (cnt_q == CntW'(Limit - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Optional wait-state timeout enabled by MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mcu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              if_stall,
  output logic              mem_stall,
  output logic              bus_err
);

  arb_state_e        state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic              in_gnt;
  logic              timeout;

  assign in_gnt = (state_q == StGntI) || (state_q == StGntD);

`ifdef MEM_ARB_TIMEOUT_EN
  arb_wait_timer #(
    .Limit(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (!in_gnt),
    .inc_i   (in_gnt && !mem_ack),
    .expire_o(timeout)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    bus_err_d    = bus_err_q;

    unique case (state_q)
      StIdle: begin
        // On a tie the side that did not win last time gets the bus.
        if (d_req && (!if_req || (last_grant_q == GrantI))) begin
          state_d      = StGntD;
          last_grant_d = GrantD;
          mem_req_d    = 1'b1;
          mem_we_d     = d_we;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end else if (if_req) begin
          state_d      = StGntI;
          last_grant_d = GrantI;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
        end
      end
      StGntI, StGntD: begin
        if (mem_ack || timeout) begin
          state_d   = StResp;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == StGntI) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : DATA_W'(NOP_INSTR);
          end else begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_ack ? mem_rdata : '0;
            end
          end
          if (!mem_ack) begin
            bus_err_d = 1'b1;
          end
        end
      end
      StResp: begin
        // Requester's req is still high from the finished access; never regrant here.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantI;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a wait-state memory model.
// Define MEM_ARB_TIMEOUT_EN for both RTL and bench to cover the timeout path.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ack, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack, mem_stall;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, bus_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .if_stall (if_stall),
    .mem_stall(mem_stall),
    .bus_err  (bus_err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic [31:0] gnt_exp_q[$];
  int unsigned if_ack_cyc[$];
  logic [31:0] last_load = 32'h0;
  int unsigned cyc = 0;
  int unsigned wait_states = 0;
  bit          mem_hang = 1'b0;
  int unsigned wcnt = 0;
  logic        mem_req_prev = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: acks after wait_states cycles of mem_req, never when hung.
  always @(negedge clk) begin
    if (!mem_req || mem_ack) begin
      mem_ack <= 1'b0;
      wcnt    <= 0;
    end else if (!mem_hang && wcnt == wait_states) begin
      mem_ack   <= 1'b1;
      mem_rdata <= mem_rd(mem_addr);
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  // Scoreboard: every ack pops an expectation; grant order checked when queued.
  always @(negedge clk) begin
    if (if_ack) begin
      if_ack_cyc.push_back(cyc);
      if (if_exp_q.size() == 0) check_val("if_ack_unexpected", {31'b0, if_ack}, 32'h0);
      else check_val("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (d_ack) begin
      if (d_exp_q.size() == 0) check_val("d_ack_unexpected", {31'b0, d_ack}, 32'h0);
      else check_val("d_rdata", d_rdata, d_exp_q.pop_front());
    end
    if (mem_req && !mem_req_prev && gnt_exp_q.size() > 0)
      check_val("grant_addr", mem_addr, gnt_exp_q.pop_front());
    mem_req_prev <= mem_req;
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
    if_exp_q.push_back(mem_rd(a));
  endtask

  task automatic data_op(input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    if (!we) last_load = mem_rd(a);
    d_exp_q.push_back(last_load);
  endtask

  task automatic wait_if_ack(input int unsigned limit, output int unsigned lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (if_ack) seen = 1'b1;
      else lat++;
    end
    check_val("if_ack_seen", {31'b0, seen}, 32'h1);
  endtask

  task automatic wait_d_ack(input int unsigned limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (d_ack) seen = 1'b1;
    end
    check_val("d_ack_seen", {31'b0, seen}, 32'h1);
  endtask

  task automatic fetch_agent(input logic [31:0] base, input int n);
    int unsigned lat;
    for (int k = 0; k < n; k++) begin
      issue_fetch(base + 32'(4 * k));
      wait_if_ack(30, lat);
      next_cyc();
    end
    if_req = 1'b0;
  endtask

  task automatic load_agent(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      data_op(1'b0, base + 32'(4 * k), 32'h0);
      wait_d_ack(30);
      next_cyc();
    end
    d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int          hold, dack, stall_cnt, gnt_cyc;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #2;
    check_val("rst_mem_req", {31'b0, mem_req}, 32'h0);
    check_val("rst_acks", {30'b0, if_ack, d_ack}, 32'h0);
    check_val("rst_mem_addr", mem_addr, 32'h0);
    check_val("rst_bus_err", {31'b0, bus_err}, 32'h0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;

    // Single fetch, zero-wait memory: cycle-exact handshake.
    wait_states = 0;
    issue_fetch(32'h100);
    @(negedge clk);
    check_val("t1_c0_stall", {31'b0, if_stall}, 32'h1);
    check_val("t1_c0_mem_req", {31'b0, mem_req}, 32'h0);
    next_cyc(); @(negedge clk);
    check_val("t1_c1_mem_req", {31'b0, mem_req}, 32'h1);
    check_val("t1_c1_mem_addr", mem_addr, 32'h100);
    check_val("t1_c1_mem_we", {31'b0, mem_we}, 32'h0);
    check_val("t1_c1_stall", {31'b0, if_stall}, 32'h1);
    next_cyc(); @(negedge clk);
    check_val("t1_c2_if_ack", {31'b0, if_ack}, 32'h1);
    check_val("t1_c2_stall", {31'b0, if_stall}, 32'h0);
    next_cyc();
    if_req = 1'b0;
    next_cyc();

    // Simultaneous requests: data first after reset, then strict alternation.
    gnt_exp_q = '{32'h2000, 32'h200, 32'h2004, 32'h204, 32'h2008, 32'h208};
    fork
      fetch_agent(32'h200, 3);
      load_agent(32'h2000, 3);
    join
    check_val("t2_grants_left", gnt_exp_q.size(), 32'h0);
    next_cyc();

    // Store with 3 wait states.
    wait_states = 3;
    data_op(1'b1, 32'h10, 32'hDEAD_BEEF);
    hold = 0; dack = 0; stall_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req && mem_we && mem_addr == 32'h10 && mem_wdata == 32'hDEAD_BEEF) hold++;
      if (mem_stall) stall_cnt++;
      if (d_ack) begin
        dack++;
        d_req = 1'b0;
      end
    end
    check_val("t3_store_hold", 32'(hold), 32'd4);
    check_val("t3_d_ack_count", 32'(dack), 32'd1);
    check_val("t3_stall_cycles", 32'(stall_cnt), 32'd5);
    check_val("t3_mem_we_after", {31'b0, mem_we}, 32'h0);
    next_cyc();

    // Reset during a waiting data grant.
    wait_states = 5;
    data_op(1'b0, 32'h40, 32'h0);
    next_cyc(); next_cyc();
    @(negedge clk);
    check_val("t4_mem_req_before", {31'b0, mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_val("t4_mem_req_async", {31'b0, mem_req}, 32'h0);
    d_req = 1'b0;
    d_exp_q.delete();
    last_load = 32'h0;
    next_cyc(); next_cyc();
    rst_n = 1'b1;
    dack = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_ack) dack++;
    end
    check_val("t4_no_d_ack", 32'(dack), 32'd0);
    check_val("t4_d_rdata_clr", d_rdata, 32'h0);
    next_cyc();
    wait_states = 0;
    issue_fetch(32'h180);
    wait_if_ack(10, lat);
    check_val("t4_fetch_latency", lat, 32'd2);
    next_cyc();
    if_req = 1'b0;
    next_cyc();

    // Continuous fetch stream: one ack every third cycle.
    if_ack_cyc.delete();
    fetch_agent(32'h400, 5);
    check_val("t6_ack_count", if_ack_cyc.size(), 32'd5);
    for (int k = 1; k < if_ack_cyc.size(); k++)
      check_val("t6_ack_interval", if_ack_cyc[k] - if_ack_cyc[k-1], 32'd3);
    next_cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never acks: timeout returns a NOP and sets the sticky error.
    check_val("t5_bus_err_pre", {31'b0, bus_err}, 32'h0);
    mem_hang = 1'b1;
    if_req = 1'b1;
    if_addr = 32'h300;
    if_exp_q.push_back(32'h0000_0013);
    gnt_cyc = 0;
    dack = 0;
    for (int i = 0; i < 40 && dack == 0; i++) begin
      @(negedge clk);
      if (mem_req) gnt_cyc++;
      if (if_ack) dack = 1;
    end
    check_val("t5_timeout_ack", 32'(dack), 32'd1);
    check_val("t5_gnt_cycles", 32'(gnt_cyc), 32'd15);
    check_val("t5_bus_err_set", {31'b0, bus_err}, 32'h1);
    mem_hang = 1'b0;
    next_cyc();
    if_req = 1'b0;
    next_cyc();
    fetch_agent(32'h500, 1);
    check_val("t5_bus_err_sticky", {31'b0, bus_err}, 32'h1);
`else
    gnt_cyc = 0;
    check_val("bus_err_tied", {31'b0, bus_err} + 32'(gnt_cyc), 32'h0);
`endif

    next_cyc(); next_cyc();
    check_val("if_exp_left", if_exp_q.size(), 32'h0);
    check_val("d_exp_left", d_exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
